// File: rtl/rv32i_instr_encoder.sv
// RV32I field-bundle encoder and program loader: encodes accepted bundles,
// buffers them in a 2-entry FIFO and writes them to consecutive imem words.
module rv32i_instr_encoder #(
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_fmt_i,
    input  logic [6:0]        req_opcode_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [6:0]        req_funct7_i,
    input  logic [4:0]        req_rd_i,
    input  logic [4:0]        req_rs1_i,
    input  logic [4:0]        req_rs2_i,
    input  logic [31:0]       req_imm_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    input  logic              imem_ready_i,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_S  = 3'd2,
        FMT_B  = 3'd3,
        FMT_U  = 3'd4,
        FMT_J  = 3'd5,
        FMT_X6 = 3'd6,
        FMT_X7 = 3'd7
    } fmt_e;

    localparam logic [ADDR_W:0]   CAPACITY = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // FIFO storage and pointers
    logic [31:0]       fifo_mem_q [2];
    logic [31:0]       fifo_mem_d [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        occ_q, occ_d;

    // Program bookkeeping
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   acc_q, acc_d;
    logic              err_q, err_d;

    logic [31:0]       enc_word;
    logic              enc_ok;
    logic              fits12, fits13, fits21;
    logic              accept, push, reject, pop;
    logic              wr_idx;

    // Sign-fit: every bit above the top immediate bit equals it.
    assign fits12 = (req_imm_i[31:11] == '0) || (req_imm_i[31:11] == '1);
    assign fits13 = (req_imm_i[31:12] == '0) || (req_imm_i[31:12] == '1);
    assign fits21 = (req_imm_i[31:20] == '0) || (req_imm_i[31:20] == '1);

    always_comb begin
        enc_word = 32'd0;
        enc_ok   = 1'b0;
        case (fmt_e'(req_fmt_i))
            FMT_R: begin
                enc_word = {req_funct7_i, req_rs2_i, req_rs1_i, req_funct3_i,
                            req_rd_i, req_opcode_i};
                enc_ok   = 1'b1;
            end
            FMT_I: begin
                enc_word = {req_imm_i[11:0], req_rs1_i, req_funct3_i,
                            req_rd_i, req_opcode_i};
                enc_ok   = fits12;
            end
            FMT_S: begin
                enc_word = {req_imm_i[11:5], req_rs2_i, req_rs1_i, req_funct3_i,
                            req_imm_i[4:0], req_opcode_i};
                enc_ok   = fits12;
            end
            FMT_B: begin
                enc_word = {req_imm_i[12], req_imm_i[10:5], req_rs2_i, req_rs1_i,
                            req_funct3_i, req_imm_i[4:1], req_imm_i[11], req_opcode_i};
                enc_ok   = fits13 && !req_imm_i[0];
            end
            FMT_U: begin
                enc_word = {req_imm_i[31:12], req_rd_i, req_opcode_i};
                enc_ok   = (req_imm_i[11:0] == 12'd0);
            end
            FMT_J: begin
                enc_word = {req_imm_i[20], req_imm_i[10:1], req_imm_i[11],
                            req_imm_i[19:12], req_rd_i, req_opcode_i};
                enc_ok   = fits21 && !req_imm_i[0];
            end
            default: begin
                enc_word = 32'd0;
                enc_ok   = 1'b0;
            end
        endcase
    end

    // A restart lifts the capacity stall so the restarting bundle can enter.
    assign req_ready_o  = (occ_q != 2'd2) && (start_i || !full_o);
    assign imem_we_o    = (occ_q != 2'd0);
    assign imem_wdata_o = fifo_mem_q[rd_ptr_q];
    assign imem_addr_o  = addr_q;
    assign count_o      = count_q;
    assign full_o       = (acc_q == CAPACITY);
    assign err_o        = err_q;

    always_comb begin
        accept = req_valid_i && req_ready_o;
        push   = accept && enc_ok;
        reject = accept && !enc_ok;
        pop    = imem_we_o && imem_ready_i && !start_i;
        wr_idx = start_i ? 1'b0 : wr_ptr_q;

        fifo_mem_d = fifo_mem_q;
        if (push) begin
            fifo_mem_d[wr_idx] = enc_word;
        end

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        addr_d   = addr_q;
        count_d  = count_q;
        acc_d    = acc_q;
        err_d    = err_q;

        if (start_i) begin
            // Buffered words are abandoned; only a concurrent bundle survives.
            rd_ptr_d = 1'b0;
            wr_ptr_d = push;
            occ_d    = {1'b0, push};
            addr_d   = BASE_ADDR;
            count_d  = '0;
            acc_d    = push ? CNT_ONE : '0;
            err_d    = reject;
        end else begin
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
                acc_d    = acc_q + CNT_ONE;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
                addr_d   = addr_q + ADDR_ONE;
                count_d  = count_q + CNT_ONE;
            end
            occ_d = occ_q + {1'b0, push} - {1'b0, pop};
            if (reject) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
            addr_q   <= BASE_ADDR;
            count_q  <= '0;
            acc_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        fifo_mem_q <= fifo_mem_d;
    end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Self-checking bench for rv32i_instr_encoder: directed scenarios plus random
// traffic, compared every cycle against a queue-based behavioural model.
module tb_rv32i_instr_encoder;

    localparam int AW   = 5;
    localparam int CAP  = 32;
    localparam int BASE = 16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_fmt;
    logic [6:0]  req_opcode;
    logic [2:0]  req_funct3;
    logic [6:0]  req_funct7;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [31:0] req_imm;
    logic        imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_ready;
    logic [AW:0] count;
    logic        full;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    rv32i_instr_encoder #(.ADDR_W(AW), .BASE_ADDR(5'h10)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_fmt_i(req_fmt), .req_opcode_i(req_opcode),
        .req_funct3_i(req_funct3), .req_funct7_i(req_funct7),
        .req_rd_i(req_rd), .req_rs1_i(req_rs1), .req_rs2_i(req_rs2),
        .req_imm_i(req_imm),
        .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
        .imem_ready_i(imem_ready), .count_o(count), .full_o(full), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    logic [31:0] m_q[$];
    int          m_count = 0;
    int          m_acc = 0;
    bit          m_err = 1'b0;
    bit          m_init = 1'b0;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;
    wr_t wlog[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_enc(input int unsigned fmt, input int unsigned op,
                                          input int unsigned f3, input int unsigned f7,
                                          input int unsigned rd, input int unsigned rs1,
                                          input int unsigned rs2, input int unsigned imm);
        int unsigned w;
        w = op;
        case (fmt)
            0: w += (rd << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20) + (f7 << 25);
            1: w += (rd << 7) + (f3 << 12) + (rs1 << 15) + ((imm & 12'hFFF) << 20);
            2: w += ((imm & 31) << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20)
                    + (((imm >> 5) & 127) << 25);
            3: w += (((imm >> 11) & 1) << 7) + (((imm >> 1) & 15) << 8) + (f3 << 12)
                    + (rs1 << 15) + (rs2 << 20) + (((imm >> 5) & 63) << 25)
                    + (((imm >> 12) & 1) << 31);
            4: w += (imm & 32'hFFFFF000) + (rd << 7);
            5: w += (rd << 7) + (((imm >> 12) & 255) << 12) + (((imm >> 11) & 1) << 20)
                    + (((imm >> 1) & 1023) << 21) + (((imm >> 20) & 1) << 31);
            default: w = 0;
        endcase
        return w;
    endfunction

    function automatic bit m_legal(input int unsigned fmt, input logic [31:0] imm);
        int s;
        s = imm;
        case (fmt)
            0: return 1'b1;
            1, 2: return (s >= -2048) && (s <= 2047);
            3: return (s >= -4096) && (s <= 4095) && (imm[0] == 1'b0);
            4: return (imm & 32'h00000FFF) == 0;
            5: return (s >= -1048576) && (s <= 1048575) && (imm[0] == 1'b0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step();
        bit acc_ok;
        bit pop_ok;
        if (!rst_n) begin
            m_q.delete();
            m_count = 0;
            m_acc = 0;
            m_err = 1'b0;
            m_init = 1'b1;
        end else if (m_init) begin
            acc_ok = req_valid && (m_q.size() < 2) && (start || m_acc < CAP);
            pop_ok = !start && (m_q.size() > 0) && imem_ready;
            if (start) begin
                m_q.delete();
                m_count = 0;
                m_acc = 0;
                m_err = 1'b0;
            end
            if (pop_ok) begin
                void'(m_q.pop_front());
                m_count++;
            end
            if (acc_ok) begin
                if (m_legal(int'(req_fmt), req_imm)) begin
                    m_q.push_back(m_enc(int'(req_fmt), int'(req_opcode), int'(req_funct3),
                                        int'(req_funct7), int'(req_rd), int'(req_rs1),
                                        int'(req_rs2), req_imm));
                    m_acc++;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_step();
        wr_t e;
        check("we", 64'(imem_we), 64'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check("addr", 64'(imem_addr), 64'((BASE + m_count) % CAP));
            check("wdata", 64'(imem_wdata), 64'(m_q[0]));
        end
        check("ready", 64'(req_ready), 64'((m_q.size() < 2) && (start || m_acc < CAP)));
        check("count", 64'(count), 64'(m_count));
        check("full", 64'(full), 64'(m_acc == CAP));
        check("err", 64'(err), 64'(m_err));
        if (rst_n && !start && imem_we && imem_ready) begin
            e.a = imem_addr;
            e.d = imem_wdata;
            wlog.push_back(e);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_init) compare_step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input int fmt_v, input int op_v, input int f3_v, input int f7_v,
                              input int rd_v, input int rs1_v, input int rs2_v,
                              input logic [31:0] imm_v);
        req_fmt    = 3'(fmt_v);
        req_opcode = 7'(op_v);
        req_funct3 = 3'(f3_v);
        req_funct7 = 7'(f7_v);
        req_rd     = 5'(rd_v);
        req_rs1    = 5'(rs1_v);
        req_rs2    = 5'(rs2_v);
        req_imm    = imm_v;
    endtask

    task automatic send(input int fmt_v, input int op_v, input int f3_v, input int f7_v,
                        input int rd_v, input int rs1_v, input int rs2_v,
                        input logic [31:0] imm_v);
        int w;
        w = 0;
        set_fields(fmt_v, op_v, f3_v, f7_v, rd_v, rs1_v, rs2_v, imm_v);
        req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got ready=0 expected handshake within 50 cycles");
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic send_addi(input int rd_v, input logic [31:0] imm_v);
        send(1, 'h13, 0, 0, rd_v, 0, 0, imm_v);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [31:0] rand_imm();
        int bnd[11] = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, -4098,
                        1048574, 1048576, -1048576};
        case ($urandom_range(0, 4))
            0: return 32'($urandom_range(0, 8000)) - 32'd4000;
            1: return $urandom();
            2: return $urandom() & 32'hFFFFF000;
            3: return 32'(bnd[$urandom_range(0, 10)]);
            default: return (32'($urandom_range(0, 4000000)) - 32'd2000000) & 32'hFFFFFFFE;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        logic [31:0] stream_w[6] = '{32'hFFF20413, 32'h123452B7, 32'h020000EF,
                                     32'h00208863, 32'h00D675B3, 32'h0071A623};
        logic [31:0] bp_w[3] = '{32'h00100093, 32'h00200113, 32'h00300193};

        rst_n = 1'b0; start = 1'b0; req_valid = 1'b0; imem_ready = 1'b1;
        set_fields(0, 0, 0, 0, 0, 0, 0, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_we", 64'(imem_we), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'h10);
        check("rst_count", 64'(count), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd1);
        tick();

        // Streaming program at BASE with memory always ready
        base = wlog.size();
        send(1, 'h13, 0, 0, 8, 4, 0, 32'hFFFFFFFF);
        send(4, 'h37, 0, 0, 5, 0, 0, 32'h12345000);
        send(5, 'h6F, 0, 0, 1, 0, 0, 32'd32);
        send(3, 'h63, 0, 0, 0, 1, 2, 32'd16);
        send(0, 'h33, 7, 0, 11, 12, 13, 32'd0);
        send(2, 'h23, 2, 0, 0, 3, 7, 32'd12);
        repeat (4) tick();
        check("stream_nwr", 64'(wlog.size() - base), 64'd6);
        if (wlog.size() >= base + 6) begin
            for (int i = 0; i < 6; i++) begin
                check("stream_word", 64'(wlog[base+i].d), 64'(stream_w[i]));
                check("stream_addr", 64'(wlog[base+i].a), 64'(16 + i));
            end
        end
        check("stream_count", 64'(count), 64'd6);

        // Backpressure: two fill the FIFO, third waits
        imem_ready = 1'b0;
        base = wlog.size();
        send_addi(1, 32'd1);
        send_addi(2, 32'd2);
        set_fields(1, 'h13, 0, 0, 3, 0, 0, 32'd3);
        req_valid = 1'b1;
        @(negedge clk);
        check("bp_ready", 64'(req_ready), 64'd0);
        repeat (3) tick();
        imem_ready = 1'b1;
        send_addi(3, 32'd3);
        repeat (5) tick();
        check("bp_nwr", 64'(wlog.size() - base), 64'd3);
        if (wlog.size() >= base + 3) begin
            for (int i = 0; i < 3; i++) begin
                check("bp_word", 64'(wlog[base+i].d), 64'(bp_w[i]));
                check("bp_addr", 64'(wlog[base+i].a), 64'(22 + i));
            end
        end

        // Unencodable bundles
        pulse_start();
        base = wlog.size();
        send(1, 'h13, 0, 0, 1, 2, 0, 32'd2048);
        send(3, 'h63, 0, 0, 0, 1, 2, 32'd5);
        send(4, 'h37, 0, 0, 5, 0, 0, 32'h00001001);
        send(6, 'h13, 0, 0, 1, 0, 0, 32'd0);
        repeat (2) tick();
        @(negedge clk);
        check("errs_err", 64'(err), 64'd1);
        check("errs_count", 64'(count), 64'd0);
        check("errs_we", 64'(imem_we), 64'd0);
        check("errs_nwr", 64'(wlog.size() - base), 64'd0);
        tick();
        send_addi(4, 32'd4);
        repeat (2) tick();
        @(negedge clk);
        check("errs_sticky", 64'(err), 64'd1);
        check("errs_count2", 64'(count), 64'd1);
        tick();

        // Fill to capacity, check wrap and full
        pulse_start();
        base = wlog.size();
        for (int i = 0; i < CAP; i++) send_addi(i, 32'(i));
        @(negedge clk);
        check("cap_full", 64'(full), 64'd1);
        check("cap_ready", 64'(req_ready), 64'd0);
        repeat (4) tick();
        check("cap_count", 64'(count), 64'd32);
        check("cap_nwr", 64'(wlog.size() - base), 64'd32);
        if (wlog.size() >= base + CAP) begin
            for (int i = 0; i < CAP; i++) begin
                check("cap_addr", 64'(wlog[base+i].a), 64'((16 + i) % 32));
                check("cap_word", 64'(wlog[base+i].d), 64'((i << 20) | (i << 7) | 'h13));
            end
        end
        pulse_start();
        @(negedge clk);
        check("cap_restart_full", 64'(full), 64'd0);
        check("cap_restart_count", 64'(count), 64'd0);
        tick();

        // Restart with a full FIFO: old words dropped
        imem_ready = 1'b0;
        base = wlog.size();
        send_addi(1, 32'd1);
        send_addi(2, 32'd2);
        start = 1'b1;
        set_fields(1, 'h13, 0, 0, 9, 0, 0, 32'hFFFFFFFF);
        req_valid = 1'b1;
        @(negedge clk);
        check("st2_ready", 64'(req_ready), 64'd0);
        tick();
        start = 1'b0;
        send_addi(9, 32'hFFFFFFFF);
        imem_ready = 1'b1;
        repeat (3) tick();
        check("st2_nwr", 64'(wlog.size() - base), 64'd1);
        if (wlog.size() == base + 1) begin
            check("st2_word", 64'(wlog[base].d), 64'hFFF00493);
            check("st2_addr", 64'(wlog[base].a), 64'h10);
        end
        check("st2_count", 64'(count), 64'd1);

        // Restart concurrent with a handshake
        imem_ready = 1'b0;
        send_addi(1, 32'd1);
        base = wlog.size();
        start = 1'b1;
        set_fields(1, 'h13, 0, 0, 9, 0, 0, 32'hFFFFFFFF);
        req_valid = 1'b1;
        @(negedge clk);
        check("st1_ready", 64'(req_ready), 64'd1);
        tick();
        start = 1'b0;
        req_valid = 1'b0;
        imem_ready = 1'b1;
        repeat (3) tick();
        check("st1_nwr", 64'(wlog.size() - base), 64'd1);
        if (wlog.size() == base + 1) begin
            check("st1_word", 64'(wlog[base].d), 64'hFFF00493);
            check("st1_addr", 64'(wlog[base].a), 64'h10);
        end
        check("st1_count", 64'(count), 64'd1);

        // Reset mid-write
        imem_ready = 1'b0;
        send_addi(5, 32'd5);
        @(negedge clk);
        check("rstm_we_before", 64'(imem_we), 64'd1);
        tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        check("rstm_we", 64'(imem_we), 64'd0);
        check("rstm_addr", 64'(imem_addr), 64'h10);
        check("rstm_count", 64'(count), 64'd0);
        check("rstm_err", 64'(err), 64'd0);
        check("rstm_full", 64'(full), 64'd0);
        tick();
        rst_n = 1'b1;

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst_n      = ($urandom_range(0, 299) != 0);
            start      = ($urandom_range(0, 149) == 0);
            req_valid  = ($urandom_range(0, 3) != 0);
            imem_ready = ($urandom_range(0, 2) != 0);
            set_fields(int'($urandom_range(0, 7)), int'($urandom_range(0, 127)),
                       int'($urandom_range(0, 7)), int'($urandom_range(0, 127)),
                       int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                       int'($urandom_range(0, 31)), rand_imm());
            tick();
        end
        rst_n = 1'b1;
        start = 1'b0;
        req_valid = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
